hazard_stall_ctrl: RTL and testbench

- Central pipeline control block. It generates the flush and hold controls that are consumed by the IF/ID, ID/EX and EX/MEM pipeline registers and by the PC.
- It detects load-use hazards between the ID stage and the ID/EX register. It also sequences taken-branch flushes and freezes the whole pipeline while data memory is not ready.
- It keeps saturating stall and flush performance counters, plus a sticky memory-timeout flag.

---
 rtl/hazard_stall_ctrl_pkg.sv | 13 +
 rtl/hazard_stall_ctrl_sat_counter.sv | 22 ++
 rtl/hazard_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_ctrl_pkg.sv
// rtl/hazard_stall_ctrl_pkg.sv - shared types and default widths for the pipeline stall controller
package hazard_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam int HZ_REG_IDX_W = 3;
    localparam int HZ_CNT_W     = 16;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// rtl/hazard_stall_ctrl_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use, branch-flush and memory-freeze control for the pipeline registers and PC
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_IDX_W      = HZ_REG_IDX_W,
    parameter int CNT_W          = HZ_CNT_W,
    parameter int BRANCH_PENALTY = 2,
    parameter int MEM_TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic                 id_use_rs1,
    input  logic                 id_use_rs2,
    input  logic                 ex_mem_read,
    input  logic                 ex_rf_write_en,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_ready,
    input  logic                 perf_clr,
    output logic                 pc_write_en,
    output logic                 pr1_write_en,
    output logic                 pr1_flush,
    output logic                 pr2_write_en,
    output logic                 pr2_flush,
    output logic                 pr3_write_en,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt,
    output logic                 mem_timeout
);

    localparam int FL_W = $clog2(BRANCH_PENALTY + 1);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [FL_W-1:0] FL_RELOAD = FL_W'(BRANCH_PENALTY - 1);
    localparam logic [WC_W-1:0] WC_MAX    = WC_W'(MEM_TIMEOUT);

    hz_state_t       state, state_next, saved_state, saved_next, eff_state;
    logic [FL_W-1:0] flush_left, flush_left_next;
    logic [WC_W-1:0] wcnt, wcnt_next, wcnt_inc;
    logic            mem_stall, load_use, flush_inc, stall_inc;

    assign mem_stall = mem_req & ~mem_ready;
    assign load_use  = ex_mem_read & ex_rf_write_en &
                       ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
    assign wcnt_inc  = (wcnt == WC_MAX) ? wcnt : wcnt + WC_W'(1);
    // On the release cycle of a freeze, behave as the state that was interrupted.
    assign eff_state = (state == MEM_WAIT) ? saved_state : state;

    always_comb begin
        pc_write_en     = 1'b1;
        pr1_write_en    = 1'b1;
        pr1_flush       = 1'b0;
        pr2_write_en    = 1'b1;
        pr2_flush       = 1'b0;
        pr3_write_en    = 1'b1;
        state_next      = eff_state;
        saved_next      = saved_state;
        flush_left_next = flush_left;
        wcnt_next       = '0;
        flush_inc       = 1'b0;
        if (!rst) begin
            pc_write_en  = 1'b0;
            pr1_write_en = 1'b0;
            pr2_write_en = 1'b0;
            pr3_write_en = 1'b0;
            pr1_flush    = 1'b1;
            pr2_flush    = 1'b1;
            state_next   = RUN;
        end else if (mem_stall) begin
            pc_write_en  = 1'b0;
            pr1_write_en = 1'b0;
            pr2_write_en = 1'b0;
            pr3_write_en = 1'b0;
            state_next   = MEM_WAIT;
            saved_next   = (state == MEM_WAIT) ? saved_state : state;
            wcnt_next    = wcnt_inc;
        end else if (branch_taken) begin
            pr1_flush = 1'b1;
            pr2_flush = 1'b1;
            flush_inc = 1'b1;
            if (BRANCH_PENALTY > 1) begin
                state_next      = FLUSH;
                flush_left_next = FL_RELOAD;
            end else begin
                state_next = RUN;
            end
        end else if (eff_state == FLUSH) begin
            pr1_flush       = 1'b1;
            pr2_flush       = 1'b1;
            flush_left_next = flush_left - FL_W'(1);
            state_next      = (flush_left <= FL_W'(1)) ? RUN : FLUSH;
        end else if (load_use) begin
            pc_write_en  = 1'b0;
            pr1_write_en = 1'b0;
            pr2_flush    = 1'b1;
        end
    end

    assign stall_inc = rst & ~pc_write_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            saved_state <= RUN;
            flush_left  <= '0;
            wcnt        <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            saved_state <= saved_next;
            flush_left  <= flush_left_next;
            wcnt        <= wcnt_next;
            if (perf_clr) begin
                mem_timeout <= 1'b0;
            end else if (mem_stall && (wcnt_inc == WC_MAX)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (perf_clr),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - scoreboard bench for hazard_stall_ctrl with directed vectors
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  id_rs1, id_rs2, ex_rd;
    logic        id_use_rs1, id_use_rs2, ex_mem_read, ex_rf_write_en;
    logic        branch_taken, mem_req, mem_ready, perf_clr;
    logic        pc_write_en, pr1_write_en, pr1_flush, pr2_write_en, pr2_flush, pr3_write_en;
    logic [15:0] stall_cnt, flush_cnt;
    logic        mem_timeout;

    // {pc_we, pr1_we, pr1_flush, pr2_we, pr2_flush, pr3_we}
    localparam logic [5:0] C_RST = 6'b001010;
    localparam logic [5:0] C_RUN = 6'b110101;
    localparam logic [5:0] C_LU  = 6'b000111;
    localparam logic [5:0] C_BR  = 6'b111111;
    localparam logic [5:0] C_FRZ = 6'b000000;

    typedef struct {
        logic [5:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
        logic        mt;
        int          idx;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   step_no = 0;

    hazard_stall_ctrl #(
        .REG_IDX_W(3), .CNT_W(16), .BRANCH_PENALTY(2), .MEM_TIMEOUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rf_write_en(ex_rf_write_en), .ex_rd(ex_rd),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
        .perf_clr(perf_clr),
        .pc_write_en(pc_write_en), .pr1_write_en(pr1_write_en), .pr1_flush(pr1_flush),
        .pr2_write_en(pr2_write_en), .pr2_flush(pr2_flush), .pr3_write_en(pr3_write_en),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    // Monitor: outputs are presented every cycle, so each negedge consumes one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({pc_write_en, pr1_write_en, pr1_flush, pr2_write_en, pr2_flush, pr3_write_en} !== e.ctl) begin
                errors++;
                $display("FAIL ctl step %0d got=%b want=%b", e.idx,
                         {pc_write_en, pr1_write_en, pr1_flush, pr2_write_en, pr2_flush, pr3_write_en}, e.ctl);
            end
            checks++;
            if (stall_cnt !== e.sc) begin
                errors++;
                $display("FAIL stall_cnt step %0d got=%0d want=%0d", e.idx, stall_cnt, e.sc);
            end
            checks++;
            if (flush_cnt !== e.fc) begin
                errors++;
                $display("FAIL flush_cnt step %0d got=%0d want=%0d", e.idx, flush_cnt, e.fc);
            end
            checks++;
            if (mem_timeout !== e.mt) begin
                errors++;
                $display("FAIL mem_timeout step %0d got=%b want=%b", e.idx, mem_timeout, e.mt);
            end
        end
    end

    task automatic idle();
        id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0; ex_rf_write_en = 1'b0;
        branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        idle();
        rst = 1'b1;
    endtask

    task automatic push(input logic [5:0] ctl, input int sc, input int fc, input logic mt);
        exp_t e;
        e.ctl = ctl; e.sc = 16'(sc); e.fc = 16'(fc); e.mt = mt; e.idx = step_no;
        q.push_back(e);
        step_no++;
    endtask

    task automatic set_lu(input logic [2:0] rd, input logic [2:0] rs1, input logic u1,
                          input logic [2:0] rs2, input logic u2);
        ex_mem_read = 1'b1; ex_rf_write_en = 1'b1; ex_rd = rd;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        cyc(); rst = 1'b0; push(C_RST, 0, 0, 1'b0);
        cyc(); push(C_RUN, 0, 0, 1'b0);

        // load-use via rs2, then non-hazards, then via rs1
        cyc(); set_lu(3'd3, 3'd0, 1'b0, 3'd3, 1'b1); push(C_LU, 0, 0, 1'b0);
        cyc(); push(C_RUN, 1, 0, 1'b0);
        cyc(); set_lu(3'd3, 3'd3, 1'b0, 3'd1, 1'b1); push(C_RUN, 1, 0, 1'b0);
        cyc(); set_lu(3'd5, 3'd5, 1'b1, 3'd0, 1'b0); ex_rf_write_en = 1'b0; push(C_RUN, 1, 0, 1'b0);
        cyc(); set_lu(3'd5, 3'd5, 1'b1, 3'd0, 1'b0); push(C_LU, 1, 0, 1'b0);
        cyc(); push(C_RUN, 2, 0, 1'b0);

        // taken branch: two flush cycles
        cyc(); branch_taken = 1'b1; push(C_BR, 2, 0, 1'b0);
        cyc(); push(C_BR, 2, 1, 1'b0);
        cyc(); push(C_RUN, 2, 1, 1'b0);

        // five-cycle freeze; timeout of 4 trips during the fifth
        for (int k = 0; k < 5; k++) begin
            cyc(); mem_req = 1'b1; push(C_FRZ, 2 + k, 1, (k >= 4));
        end
        cyc(); mem_req = 1'b1; mem_ready = 1'b1; push(C_RUN, 7, 1, 1'b1);
        cyc(); push(C_RUN, 7, 1, 1'b1);
        cyc(); perf_clr = 1'b1; push(C_RUN, 7, 1, 1'b1);
        cyc(); push(C_RUN, 0, 0, 1'b0);

        // freeze + branch + load-use together
        cyc(); mem_req = 1'b1; branch_taken = 1'b1; set_lu(3'd2, 3'd2, 1'b1, 3'd0, 1'b0); push(C_FRZ, 0, 0, 1'b0);
        cyc(); mem_req = 1'b1; branch_taken = 1'b1; set_lu(3'd2, 3'd2, 1'b1, 3'd0, 1'b0); push(C_FRZ, 1, 0, 1'b0);
        cyc(); mem_req = 1'b1; mem_ready = 1'b1; branch_taken = 1'b1; set_lu(3'd2, 3'd2, 1'b1, 3'd0, 1'b0);
        push(C_BR, 2, 0, 1'b0);
        cyc(); push(C_BR, 2, 1, 1'b0);
        cyc(); push(C_RUN, 2, 1, 1'b0);
        // clear wins over a same-cycle stall increment
        cyc(); perf_clr = 1'b1; set_lu(3'd4, 3'd0, 1'b0, 3'd4, 1'b1); push(C_LU, 2, 1, 1'b0);
        cyc(); push(C_RUN, 0, 0, 1'b0);

        // six-cycle wait: timeout rises after the fourth, stays sticky
        for (int k = 0; k < 6; k++) begin
            cyc(); mem_req = 1'b1; push(C_FRZ, k, 0, (k >= 4));
        end
        cyc(); mem_req = 1'b1; mem_ready = 1'b1; push(C_RUN, 6, 0, 1'b1);
        cyc(); push(C_RUN, 6, 0, 1'b1);
        cyc(); perf_clr = 1'b1; push(C_RUN, 6, 0, 1'b1);
        cyc(); push(C_RUN, 0, 0, 1'b0);

        // reset in the FLUSH cycle
        cyc(); branch_taken = 1'b1; push(C_BR, 0, 0, 1'b0);
        cyc(); rst = 1'b0; push(C_RST, 0, 0, 1'b0);
        cyc(); push(C_RUN, 0, 0, 1'b0);
        cyc(); push(C_RUN, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending want=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
